instr_fetch_buffer: RTL and testbench

INSTR_FETCH_BUFFER -- requirements
Module: instr_fetch_buffer

---
 rtl/instr_fetch_buffer_pkg.sv | 23 ++
 rtl/instr_fetch_buffer_if.sv | 33 +++
 rtl/fetch_fifo.sv | 70 +++++++
 rtl/instr_fetch_buffer.sv | 128 ++++++++++++
 tb/tb_instr_fetch_buffer.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/instr_fetch_buffer_pkg.sv
// Shared types and constants for the instruction fetch buffer.
// Holds the fetch FSM state enum, the word width and the default FIFO depth.
package fetch_pkg;

    localparam int WORD_W        = 32;
    localparam int DEPTH_DEFAULT = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } fetch_state_e;

    // One buffered instruction together with the word address it was fetched from.
    typedef struct packed {
        logic [WORD_W-1:0] pc;
        logic [WORD_W-1:0] instr;
    } fetch_entry_t;

    function automatic logic [WORD_W-1:0] pc_incr(input logic [WORD_W-1:0] pc);
        return pc + WORD_W'(1);
    endfunction

endpackage

// File: rtl/instr_fetch_buffer_if.sv
// Bus bundle between the fetch buffer, instruction memory, redirect source and decode.
// master = the fetch buffer, slave = its environment.
interface fetch_if;
    import fetch_pkg::*;

    // Handshakes:
    //   imem_req/imem_addr: one read per asserted cycle, no back-pressure;
    //     imem_rdata must hold the word for that address exactly one cycle later.
    //   out_valid/out_ready: head is consumed on a cycle where both are high;
    //     out_valid never depends on out_ready, and out_instr/out_pc are stable
    //     while out_valid is high and out_ready is low.
    //   redirect_valid: single-cycle request, always accepted, no ready.
    logic              redirect_valid;
    logic [WORD_W-1:0] redirect_pc;
    logic              imem_req;
    logic [WORD_W-1:0] imem_addr;
    logic [WORD_W-1:0] imem_rdata;
    logic              out_valid;
    logic [WORD_W-1:0] out_instr;
    logic [WORD_W-1:0] out_pc;
    logic              out_ready;

    modport master (
        input  redirect_valid, redirect_pc, imem_rdata, out_ready,
        output imem_req, imem_addr, out_valid, out_instr, out_pc
    );

    modport slave (
        output redirect_valid, redirect_pc, imem_rdata, out_ready,
        input  imem_req, imem_addr, out_valid, out_instr, out_pc
    );

endinterface

// File: rtl/fetch_fifo.sv
// Circular FIFO of fetched instructions with synchronous clear.
// Clear wins over push and pop; push and pop together keep the count unchanged.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_i,
    input  fetch_entry_t           push_data_i,
    input  logic                   pop_i,
    input  logic                   clear_i,
    output fetch_entry_t           head_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    fetch_entry_t     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop_i) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push_i, pop_i})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (push_i && !clear_i) begin
                mem_q[wr_ptr_q] <= push_data_i;
            end
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/instr_fetch_buffer.sv
// Prefetching instruction buffer: credit-limited memory requests feeding a FIFO toward decode.
// Optional macro FETCH_PERF_EN adds perf_fetched / perf_flushed counters.
module instr_fetch_buffer
    import fetch_pkg::*;
#(
    parameter int                DEPTH    = DEPTH_DEFAULT,
    parameter logic [WORD_W-1:0] RESET_PC = 32'd0
) (
    input  logic                   clk,
    input  logic                   rst,
    fetch_if.master                bus,
    output fetch_state_e           state_o,
    output logic [$clog2(DEPTH):0] count_o
`ifdef FETCH_PERF_EN
    ,
    output logic [WORD_W-1:0]      perf_fetched,
    output logic [WORD_W-1:0]      perf_flushed
`endif
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    fetch_state_e      state_q, state_d;
    logic [WORD_W-1:0] fetch_pc_q, fetch_pc_d;
    logic              inflight_q, inflight_d;
    logic [WORD_W-1:0] inflight_pc_q, inflight_pc_d;

    logic [CNT_W-1:0]  count;
    logic [CNT_W:0]    occupied;
    logic              req;
    logic              push;
    logic              pop;
    fetch_entry_t      push_data;
    fetch_entry_t      head;

    // Buffered plus in-flight words; a request only goes out if it is sure to find a slot.
    assign occupied = {1'b0, count} + (CNT_W + 1)'(inflight_q);

    always_comb begin
        state_d = state_q;
        req     = 1'b0;
        case (state_q)
            IDLE: begin
                state_d = FETCH;
            end
            FETCH: begin
                req = !rst && !bus.redirect_valid && (occupied < (CNT_W + 1)'(DEPTH));
            end
        endcase
    end

    always_comb begin
        pop           = (count != '0) && bus.out_ready;
        push          = inflight_q && !bus.redirect_valid;
        push_data     = '{pc: inflight_pc_q, instr: bus.imem_rdata};
        inflight_d    = req;
        inflight_pc_d = req ? fetch_pc_q : inflight_pc_q;
        fetch_pc_d    = fetch_pc_q;
        if (bus.redirect_valid) begin
            fetch_pc_d = bus.redirect_pc;
        end else if (req) begin
            fetch_pc_d = pc_incr(fetch_pc_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            fetch_pc_q    <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
        end
    end

    // A redirect clears the buffer even when decode takes the head in the same cycle.
    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push),
        .push_data_i (push_data),
        .pop_i       (pop),
        .clear_i     (bus.redirect_valid),
        .head_o      (head),
        .count_o     (count)
    );

    assign bus.imem_req  = req;
    assign bus.imem_addr = fetch_pc_q;
    assign bus.out_valid = (count != '0);
    assign bus.out_instr = head.instr;
    assign bus.out_pc    = head.pc;
    assign state_o       = state_q;
    assign count_o       = count;

`ifdef FETCH_PERF_EN
    logic [WORD_W-1:0] perf_fetched_q;
    logic [WORD_W-1:0] perf_flushed_q;
    logic [CNT_W:0]    discarded;

    // Whatever decode takes in the redirect cycle is delivered, not discarded.
    assign discarded = occupied - (CNT_W + 1)'(pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetched_q <= '0;
            perf_flushed_q <= '0;
        end else begin
            if (push) begin
                perf_fetched_q <= perf_fetched_q + WORD_W'(1);
            end
            if (bus.redirect_valid) begin
                perf_flushed_q <= perf_flushed_q + WORD_W'(discarded);
            end
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_flushed = perf_flushed_q;
`endif

endmodule

// File: tb/tb_instr_fetch_buffer.sv
// Directed bench for instr_fetch_buffer: memory model returns addr+100, a queue
// scoreboard follows every request and pop; a second instance starts at 32'hFFFFFFFE.
module tb_instr_fetch_buffer;
    import fetch_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fetch_if bus ();
    fetch_if bus_w ();

    fetch_state_e state;
    fetch_state_e state_w;
    logic [2:0]   cnt;
    logic [2:0]   cnt_w;
`ifdef FETCH_PERF_EN
    logic [31:0]  pf, pfl, pf_w, pfl_w;
`endif

    instr_fetch_buffer #(
        .DEPTH    (4),
        .RESET_PC (32'd0)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .state_o (state),
        .count_o (cnt)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched (pf),
        .perf_flushed (pfl)
`endif
    );

    instr_fetch_buffer #(
        .DEPTH    (4),
        .RESET_PC (32'hFFFF_FFFE)
    ) dut_wrap (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus_w),
        .state_o (state_w),
        .count_o (cnt_w)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched (pf_w),
        .perf_flushed (pfl_w)
`endif
    );

    // Instruction memory: data for the address requested last cycle.
    always @(posedge clk) begin
        bus.imem_rdata   <= bus.imem_addr + 32'd100;
        bus_w.imem_rdata <= bus_w.imem_addr + 32'd100;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: requests become expected entries one cycle later unless redirected.
    logic [63:0] exp_q[$];
    logic        pend_v = 1'b0;
    logic [63:0] pend   = '0;
    logic [63:0] exp_head;

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            pend_v = 1'b0;
        end else begin
            check("sb_out_valid", 64'(bus.out_valid), 64'(exp_q.size() != 0));
            check("sb_count", 64'(cnt), 64'(exp_q.size()));
            if (bus.out_valid && bus.out_ready && exp_q.size() != 0) begin
                exp_head = exp_q.pop_front();
                check("sb_head", {bus.out_pc, bus.out_instr}, exp_head);
            end
            if (bus.redirect_valid) begin
                check("sb_redirect_noreq", 64'(bus.imem_req), 64'd0);
                exp_q.delete();
                pend_v = 1'b0;
            end else if (pend_v) begin
                exp_q.push_back(pend);
            end
            pend_v = bus.imem_req;
            pend   = {bus.imem_addr, bus.imem_addr + 32'd100};
        end
    end

    logic [31:0] wrap_seen[$];
    always @(negedge clk) begin
        if (!rst && bus_w.imem_req && wrap_seen.size() < 4) begin
            wrap_seen.push_back(bus_w.imem_addr);
        end
    end

    task automatic step(input logic r, input logic rv, input logic [31:0] rpc, input logic rs);
        @(posedge clk);
        #1;
        bus.out_ready      = r;
        bus.redirect_valid = rv;
        bus.redirect_pc    = rpc;
        rst                = rs;
        #1;
    endtask

    logic [31:0] wrap_exp[4];
    int          next_addr;
    logic        found;

    initial begin
        bus.out_ready        = 1'b1;
        bus.redirect_valid   = 1'b0;
        bus.redirect_pc      = '0;
        bus_w.out_ready      = 1'b1;
        bus_w.redirect_valid = 1'b0;
        bus_w.redirect_pc    = '0;
        wrap_exp[0] = 32'hFFFF_FFFE;
        wrap_exp[1] = 32'hFFFF_FFFF;
        wrap_exp[2] = 32'h0000_0000;
        wrap_exp[3] = 32'h0000_0001;

        // Reset values and free-running fetch with decode always ready.
        repeat (3) step(1'b1, 1'b0, '0, 1'b1);
        check("rst_state", 64'(state), 64'(IDLE));
        check("rst_req", 64'(bus.imem_req), 64'd0);
        check("rst_addr", 64'(bus.imem_addr), 64'd0);
        check("rst_valid", 64'(bus.out_valid), 64'd0);
        check("rst_instr", 64'(bus.out_instr), 64'd0);
        check("rst_pc", 64'(bus.out_pc), 64'd0);
        check("rst_count", 64'(cnt), 64'd0);
`ifdef FETCH_PERF_EN
        check("rst_perf_fetched", 64'(pf), 64'd0);
        check("rst_perf_flushed", 64'(pfl), 64'd0);
`endif
        step(1'b1, 1'b0, '0, 1'b0);
        check("c0_state", 64'(state), 64'(IDLE));
        check("c0_req", 64'(bus.imem_req), 64'd0);
        step(1'b1, 1'b0, '0, 1'b0);
        check("c1_state", 64'(state), 64'(FETCH));
        check("c1_req", {31'd0, bus.imem_req, bus.imem_addr}, {31'd0, 1'b1, 32'd0});
        check("c1_valid", 64'(bus.out_valid), 64'd0);
        step(1'b1, 1'b0, '0, 1'b0);
        check("c2_req", {31'd0, bus.imem_req, bus.imem_addr}, {31'd0, 1'b1, 32'd1});
        check("c2_valid", 64'(bus.out_valid), 64'd0);
        step(1'b1, 1'b0, '0, 1'b0);
        check("c3_valid", 64'(bus.out_valid), 64'd1);
        check("c3_head", {bus.out_pc, bus.out_instr}, {32'd0, 32'd100});
        for (int k = 1; k <= 8; k++) begin
            step(1'b1, 1'b0, '0, 1'b0);
            check("stream_head", {bus.out_pc, bus.out_instr}, {32'(k), 32'(k) + 32'd100});
            check("stream_req", {31'd0, bus.imem_req, bus.imem_addr}, {31'd0, 1'b1, 32'(k + 2)});
        end
        check("wrap_count", 64'(wrap_seen.size()), 64'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < wrap_seen.size()) check("wrap_addr", 64'(wrap_seen[i]), 64'(wrap_exp[i]));
        end

        // Decode stalled from reset: credit stops fetch at DEPTH words.
        repeat (2) step(1'b0, 1'b0, '0, 1'b1);
        step(1'b0, 1'b0, '0, 1'b0);
        next_addr = 0;
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b0, '0, 1'b0);
            if (bus.imem_req) begin
                check("stall_addr", 64'(bus.imem_addr), 64'(next_addr));
                next_addr++;
            end
        end
        check("stall_nreq", 64'(next_addr), 64'd4);
        check("stall_valid", 64'(bus.out_valid), 64'd1);
        check("stall_count", 64'(cnt), 64'd4);
        check("stall_head", 64'(bus.out_pc), 64'd0);
        step(1'b1, 1'b0, '0, 1'b0);
        check("release_req0", 64'(bus.imem_req), 64'd0);
        step(1'b1, 1'b0, '0, 1'b0);
        check("release_req1", {31'd0, bus.imem_req, bus.imem_addr}, {31'd0, 1'b1, 32'd4});
        next_addr = 5;

        // Bursty decode: stalls long enough to fill, then bursts of acceptance.
        for (int i = 0; i < 60; i++) begin
            if ((i / 10) % 2 == 0) step($urandom_range(0, 3) == 0, 1'b0, '0, 1'b0);
            else                   step($urandom_range(0, 3) != 0, 1'b0, '0, 1'b0);
            if (cnt == 3'd4) check("full_noreq", 64'(bus.imem_req), 64'd0);
            if (bus.imem_req) begin
                check("burst_addr", 64'(bus.imem_addr), 64'(next_addr));
                next_addr++;
            end
        end

        // Redirect while the word at address 5 is in flight, decode ready.
        repeat (2) step(1'b1, 1'b0, '0, 1'b1);
        step(1'b1, 1'b0, '0, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step(1'b1, 1'b0, '0, 1'b0);
            if (bus.imem_req && bus.imem_addr == 32'd5) found = 1'b1;
        end
        check("redir_found_addr5", 64'(found), 64'd1);
        step(1'b1, 1'b1, 32'h40, 1'b0);
        check("redir_noreq", 64'(bus.imem_req), 64'd0);
        step(1'b1, 1'b0, '0, 1'b0);
        check("redir_valid0", 64'(bus.out_valid), 64'd0);
        check("redir_req", {31'd0, bus.imem_req, bus.imem_addr}, {31'd0, 1'b1, 32'h40});
        step(1'b1, 1'b0, '0, 1'b0);
        check("redir_valid1", 64'(bus.out_valid), 64'd0);
        check("redir_req2", 64'(bus.imem_addr), 64'h41);
        step(1'b1, 1'b0, '0, 1'b0);
        check("redir_head", {31'd0, bus.out_valid, bus.out_pc}, {31'd0, 1'b1, 32'h40});

        // Redirect during the IDLE cycle, then reset against a simultaneous redirect.
        step(1'b1, 1'b0, '0, 1'b1);
        step(1'b1, 1'b1, 32'h200, 1'b0);
        check("idle_redir_state", 64'(state), 64'(IDLE));
        step(1'b1, 1'b0, '0, 1'b0);
        check("idle_redir_req", {31'd0, bus.imem_req, bus.imem_addr}, {31'd0, 1'b1, 32'h200});
        repeat (3) step(1'b1, 1'b0, '0, 1'b0);
        step(1'b1, 1'b1, 32'h300, 1'b1);
        step(1'b1, 1'b0, '0, 1'b0);
        check("rst_prio_addr", 64'(bus.imem_addr), 64'd0);
        check("rst_prio_state", 64'(state), 64'(IDLE));
        check("rst_prio_count", 64'(cnt), 64'd0);

`ifdef FETCH_PERF_EN
        // Ten pushes, then redirect with three buffered and one in flight.
        repeat (2) step(1'b1, 1'b0, '0, 1'b1);
        step(1'b1, 1'b0, '0, 1'b0);
        for (int c = 1; c <= 12; c++) begin
            step(c < 10, c == 12, 32'h80, 1'b0);
        end
        check("perf_pre_count", 64'(cnt), 64'd3);
        step(1'b0, 1'b0, '0, 1'b0);
        check("perf_fetched", 64'(pf), 64'd10);
        check("perf_flushed", 64'(pfl), 64'd4);
`endif

        repeat (4) step(1'b1, 1'b0, '0, 1'b0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
